// File: rtl/timer_ctrl.sv
// Bus-facing control block for the 24-bit down-counter timer.
// Holds the preload value, runs the prescaler and turns timer expiries into status flags and an interrupt.
module timer_ctrl #(
    parameter logic [7:0]  PRESCALE_RST = 8'd0,
    parameter logic [23:0] LOAD_RST     = 24'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  addr,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    input  logic [23:0] timer_count,
    input  logic        timer_zero,
    output logic [23:0] load_number,
    output logic        clken,
    output logic        timer_reset,
    output logic        irq
);

    logic [15:0] r_shadow;
    logic [23:0] r_load;
    logic        r_commit;
    logic        r_en;
    logic        r_ie;
    logic [7:0]  r_prescale;
    logic [7:0]  r_pcnt;
    logic        r_clken;
    logic        r_clken_d;
    logic        r_expired;
    logic        r_ovr;
    logic [15:0] r_rdata;
    logic [7:0]  r_snapshot;

    logic w_wr_lo;
    logic w_wr_hi;
    logic w_wr_ctrl;
    logic w_wr_stat;
    logic w_rd_stat;
    logic w_event;
    logic w_clr_exp;
    logic w_clr_ovr;

    assign w_wr_lo   = wr_en & (addr == 2'd0);
    assign w_wr_hi   = wr_en & (addr == 2'd1);
    assign w_wr_ctrl = wr_en & (addr == 2'd2);
    assign w_wr_stat = wr_en & (addr == 2'd3);
    assign w_rd_stat = rd_en & (addr == 2'd3);

    // The timer's output settles on the clken edge, so expiry is judged one cycle after clken.
    assign w_event   = r_clken_d & timer_zero;
    assign w_clr_exp = w_rd_stat | (w_wr_stat & wdata[0]);
    assign w_clr_ovr = w_rd_stat | (w_wr_stat & wdata[1]);

    assign rdata       = r_rdata;
    assign load_number = r_load;
    assign clken       = r_clken;
    assign timer_reset = reset | r_commit;
    assign irq         = r_ie & r_expired;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_shadow   <= 16'd0;
            r_load     <= LOAD_RST;
            r_commit   <= 1'b0;
            r_en       <= 1'b0;
            r_ie       <= 1'b0;
            r_prescale <= PRESCALE_RST;
        end else begin
            r_commit <= 1'b0;
            if (w_wr_lo) begin
                r_shadow <= wdata;
            end
            if (w_wr_hi) begin
                r_load   <= {wdata[7:0], r_shadow};
                r_commit <= 1'b1;
            end
            if (w_wr_ctrl) begin
                r_prescale <= wdata[15:8];
                r_ie       <= wdata[1];
                r_en       <= wdata[0];
            end
        end
    end

    // A CTRL write or a commit restarts the prescale period and swallows any terminal count.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pcnt    <= 8'd0;
            r_clken   <= 1'b0;
            r_clken_d <= 1'b0;
        end else begin
            r_clken_d <= r_clken;
            if (w_wr_ctrl || r_commit || !r_en) begin
                r_pcnt  <= 8'd0;
                r_clken <= 1'b0;
            end else if (r_pcnt == r_prescale) begin
                r_pcnt  <= 8'd0;
                r_clken <= 1'b1;
            end else begin
                r_pcnt  <= r_pcnt + 8'd1;
                r_clken <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_expired <= 1'b0;
            r_ovr     <= 1'b0;
        end else begin
            if (w_event) begin
                r_expired <= 1'b1;
            end else if (w_clr_exp) begin
                r_expired <= 1'b0;
            end
            if (w_event && r_expired) begin
                r_ovr <= 1'b1;
            end else if (w_clr_ovr) begin
                r_ovr <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rdata    <= 16'd0;
            r_snapshot <= 8'd0;
        end else if (rd_en) begin
            case (addr)
                2'd0: begin
                    r_rdata    <= timer_count[15:0];
                    r_snapshot <= timer_count[23:16];
                end
                2'd1:    r_rdata <= {8'h00, r_snapshot};
                2'd2:    r_rdata <= {r_prescale, 6'b0, r_ie, r_en};
                default: r_rdata <= {14'b0, r_ovr, r_expired};
            endcase
        end
    end

endmodule

// File: tb/tb_timer_ctrl.sv
// Self-checking bench for timer_ctrl: directed scenarios plus randomized status traffic
// checked against an arithmetic model of the prescaler and expiry flags.
module tb_timer_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  addr;
    logic        wr_en;
    logic        rd_en;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic [23:0] timer_count;
    logic        timer_zero;
    logic [23:0] load_number;
    logic        clken;
    logic        timer_reset;
    logic        irq;

    int n_vec = 0;
    int n_err = 0;

    // Timer stand-in: either a behavioural down counter or values driven directly by tests.
    logic        use_model = 1'b0;
    logic        tz_drv = 1'b0;
    logic [23:0] tc_drv = 24'd0;
    logic [23:0] tcnt;

    assign timer_zero  = use_model ? (tcnt == 24'd0) : tz_drv;
    assign timer_count = use_model ? tcnt : tc_drv;

    always @(posedge clk) begin
        if (timer_reset) tcnt <= load_number;
        else if (clken)  tcnt <= (tcnt == 24'd0) ? load_number : tcnt - 24'd1;
    end

    timer_ctrl dut (
        .clk(clk), .reset(reset), .addr(addr), .wr_en(wr_en), .rd_en(rd_en),
        .wdata(wdata), .rdata(rdata), .timer_count(timer_count), .timer_zero(timer_zero),
        .load_number(load_number), .clken(clken), .timer_reset(timer_reset), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [15:0] d);
        addr = a; wdata = d; wr_en = 1'b1;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [15:0] d);
        addr = a; rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        d = rdata;
    endtask

    function automatic bit ck(int j, int p);
        return (j >= 1) && (j % (p + 1) == 0);
    endfunction

    task automatic test_reset();
        logic [15:0] d;
        reset = 1'b1; addr = 2'd0; wr_en = 1'b0; rd_en = 1'b0; wdata = 16'd0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++;
            if ({timer_reset, clken, irq} !== 3'b100 || rdata !== 16'h0000 || load_number !== 24'd0) begin
                n_err++;
                $display("FAIL reset_state: trst/clken/irq=%b rdata=%h load=%h, want 100/0000/000000",
                         {timer_reset, clken, irq}, rdata, load_number);
            end
        end
        reset = 1'b0;
        tick();
        n_vec++;
        if (timer_reset !== 1'b0) begin
            n_err++; $display("FAIL reset_release: timer_reset=%b want 0", timer_reset);
        end
        bus_read(2'd2, d);
        n_vec++;
        if (d !== 16'h0000) begin n_err++; $display("FAIL reset_ctrl: got %h want 0000", d); end
        bus_read(2'd3, d);
        n_vec++;
        if (d !== 16'h0000 || irq !== 1'b0 || clken !== 1'b0) begin
            n_err++; $display("FAIL reset_status: got %h irq=%b clken=%b want 0000/0/0", d, irq, clken);
        end
    endtask

    task automatic test_load();
        logic [15:0] lo, hi;
        bus_write(2'd0, 16'h0005);
        n_vec++;
        if (load_number !== 24'd0 || timer_reset !== 1'b0) begin
            n_err++; $display("FAIL load_lo_only: load=%h trst=%b want 000000/0", load_number, timer_reset);
        end
        bus_write(2'd1, 16'h0000);
        n_vec++;
        if (load_number !== 24'h000005 || timer_reset !== 1'b1) begin
            n_err++; $display("FAIL load_commit: load=%h trst=%b want 000005/1", load_number, timer_reset);
        end
        tick();
        n_vec++;
        if (timer_reset !== 1'b0) begin
            n_err++; $display("FAIL load_pulse_width: trst=%b want 0", timer_reset);
        end
        for (int i = 0; i < 4; i++) begin
            lo = 16'($urandom); hi = 16'($urandom);
            bus_write(2'd0, lo);
            bus_write(2'd1, hi);
            n_vec++;
            if (load_number !== {hi[7:0], lo} || timer_reset !== 1'b1) begin
                n_err++; $display("FAIL load_rand: load=%h trst=%b want %h/1", load_number, timer_reset, {hi[7:0], lo});
            end
        end
    endtask

    task automatic test_prescaler();
        logic [15:0] d;
        int p;
        logic ie;
        use_model = 1'b0; tz_drv = 1'b0;
        for (int t = 0; t < 5; t++) begin
            p  = (t == 0) ? 3 : (t == 1) ? 0 : $urandom_range(0, 7);
            ie = 1'($urandom_range(0, 1));
            bus_write(2'd2, {8'(p), 6'b0, ie, 1'b1});
            for (int j = 1; j <= 16; j++) begin
                tick();
                n_vec++;
                if (clken !== ck(j, p)) begin
                    n_err++; $display("FAIL prescale_p%0d_cyc%0d: clken=%b want %b", p, j, clken, ck(j, p));
                end
            end
            bus_read(2'd2, d);
            n_vec++;
            if (d !== {8'(p), 6'b0, ie, 1'b1}) begin
                n_err++; $display("FAIL ctrl_readback: got %h want %h", d, {8'(p), 6'b0, ie, 1'b1});
            end
        end
        bus_write(2'd2, 16'h0300);
        for (int j = 0; j < 8; j++) begin
            tick();
            n_vec++;
            if (clken !== 1'b0) begin n_err++; $display("FAIL prescale_disabled: clken=%b want 0", clken); end
        end
    endtask

    task automatic test_expiry();
        logic [15:0] d;
        bit seen;
        bus_read(2'd3, d);
        use_model = 1'b1;
        bus_write(2'd0, 16'h0005);
        bus_write(2'd1, 16'h0000);
        bus_write(2'd2, 16'h0003);
        n_vec++;
        if (irq !== 1'b0) begin n_err++; $display("FAIL expiry_pre: irq=%b want 0", irq); end
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            seen = (irq === 1'b1);
        end
        n_vec++;
        if (!seen) begin n_err++; $display("FAIL expiry_irq: irq=0 after 20 cycles, want 1"); end
        repeat (8) tick();
        bus_write(2'd2, 16'h0002);
        repeat (3) tick();
        bus_read(2'd3, d);
        n_vec++;
        if (d !== 16'h0003 || irq !== 1'b0) begin
            n_err++; $display("FAIL expiry_overrun: got %h irq=%b want 0003/0", d, irq);
        end
        bus_read(2'd3, d);
        n_vec++;
        if (d !== 16'h0000) begin n_err++; $display("FAIL expiry_cleared: got %h want 0000", d); end
        use_model = 1'b0;
    endtask

    task automatic test_simultaneous();
        logic [15:0] d;
        tz_drv = 1'b0;
        bus_write(2'd2, 16'h0000);
        bus_read(2'd3, d);
        bus_write(2'd2, 16'h0001);
        repeat (3) tick();
        // Event lands in the same cycle as the STATUS read.
        tz_drv = 1'b1; addr = 2'd3; rd_en = 1'b1;
        tick();
        tz_drv = 1'b0; rd_en = 1'b0;
        n_vec++;
        if (rdata !== 16'h0000) begin n_err++; $display("FAIL coinc_read_old: got %h want 0000", rdata); end
        bus_read(2'd3, d);
        n_vec++;
        if (d !== 16'h0001 || irq !== 1'b0) begin
            n_err++; $display("FAIL coinc_read_set: got %h irq=%b want 0001/0", d, irq);
        end
        tz_drv = 1'b1;
        tick();
        // Event lands in the same cycle as a write-1-to-clear of both flags.
        addr = 2'd3; wdata = 16'h0003; wr_en = 1'b1;
        tick();
        wr_en = 1'b0; tz_drv = 1'b0;
        bus_read(2'd3, d);
        n_vec++;
        if (d !== 16'h0003) begin n_err++; $display("FAIL coinc_clear: got %h want 0003", d); end
        bus_write(2'd2, 16'h0000);
    endtask

    task automatic test_status_random();
        logic [15:0] d;
        int p, op;
        logic ie, tz, e, o, ev, ce, co, rd;
        logic [1:0] wb;
        tz_drv = 1'b0;
        bus_write(2'd2, 16'h0000);
        repeat (2) tick();
        bus_read(2'd3, d);
        p  = $urandom_range(0, 3);
        ie = 1'($urandom_range(0, 1));
        bus_write(2'd2, {8'(p), 6'b0, ie, 1'b1});
        e = 1'b0; o = 1'b0;
        for (int j = 0; j < 300; j++) begin
            op = $urandom_range(0, 9);
            tz = ($urandom_range(0, 2) == 0);
            wb = 2'($urandom_range(0, 3));
            rd = (op <= 2);
            tz_drv = tz; addr = 2'd3; wdata = {14'b0, wb};
            rd_en = rd; wr_en = (op == 3 || op == 4);
            tick();
            rd_en = 1'b0; wr_en = 1'b0;
            ev = ck(j - 1, p) & tz;
            ce = rd | ((op == 3 || op == 4) & wb[0]);
            co = rd | ((op == 3 || op == 4) & wb[1]);
            if (rd) begin
                n_vec++;
                if (rdata !== {14'b0, o, e}) begin
                    n_err++; $display("FAIL rand_status_read@%0d: got %h want %h", j, rdata, {14'b0, o, e});
                end
            end
            o = (ev & e) ? 1'b1 : (co ? 1'b0 : o);
            e = ev ? 1'b1 : (ce ? 1'b0 : e);
            n_vec++;
            if (irq !== (ie & e) || clken !== ck(j + 1, p)) begin
                n_err++; $display("FAIL rand_irq_clken@%0d: irq=%b clken=%b want %b/%b",
                                  j, irq, clken, ie & e, ck(j + 1, p));
            end
        end
        tz_drv = 1'b0;
        bus_write(2'd2, 16'h0000);
    endtask

    task automatic test_snapshot();
        logic [15:0] d;
        logic [23:0] a;
        use_model = 1'b0;
        for (int i = 0; i < 6; i++) begin
            a = (i == 0) ? 24'hAB1234 : 24'($urandom);
            tc_drv = a;
            bus_read(2'd0, d);
            n_vec++;
            if (d !== a[15:0]) begin n_err++; $display("FAIL snap_lo: got %h want %h", d, a[15:0]); end
            tc_drv = (i == 0) ? 24'hCD0000 : 24'($urandom);
            tick();
            bus_read(2'd1, d);
            n_vec++;
            if (d !== {8'h00, a[23:16]}) begin n_err++; $display("FAIL snap_hi: got %h want %h", d, {8'h00, a[23:16]}); end
        end
    endtask

    task automatic test_reset_mid_access();
        logic [15:0] d;
        bus_write(2'd2, 16'h0503);
        bus_write(2'd0, 16'h1111);
        addr = 2'd1; wdata = 16'h00FF; wr_en = 1'b1; reset = 1'b1;
        tick();
        wr_en = 1'b0; reset = 1'b0;
        tick();
        n_vec++;
        if (load_number !== 24'd0 || timer_reset !== 1'b0) begin
            n_err++; $display("FAIL reset_mid_write: load=%h trst=%b want 000000/0", load_number, timer_reset);
        end
        bus_read(2'd2, d);
        n_vec++;
        if (d !== 16'h0000) begin n_err++; $display("FAIL reset_mid_ctrl: got %h want 0000", d); end
        bus_write(2'd1, 16'h0077);
        n_vec++;
        if (load_number !== 24'h770000) begin
            n_err++; $display("FAIL reset_mid_shadow: load=%h want 770000", load_number);
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_prescaler();
        test_expiry();
        test_simultaneous();
        test_status_random();
        test_snapshot();
        test_reset_mid_access();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
